// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and oversampling constants.
// UART_TX_PARITY_EN widens the state to 3 bits and adds the PARITY state.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;
`endif

endpackage

// File: rtl/uart_tx.sv
// UART transmitter driven by the shared 16x s_tick: start, DBIT data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop period.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_ready,
  output logic       tx_done_tick,
  output logic       tx
);

  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  uart_state_t state, state_n;
  logic [4:0]  s, s_n;
  logic [2:0]  n, n_n;
  logic [7:0]  b, b_n;
  logic        tx_reg, tx_n;
  logic        done;
`ifdef UART_TX_PARITY_EN
  logic        p_reg, p_n;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      tx_reg <= 1'b1;
`ifdef UART_TX_PARITY_EN
      p_reg  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      s      <= s_n;
      n      <= n_n;
      b      <= b_n;
      tx_reg <= tx_n;
`ifdef UART_TX_PARITY_EN
      p_reg  <= p_n;
`endif
    end
  end

  // tx_n is the level of the bit being entered, so tx stays a pure register output
  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    tx_n    = tx_reg;
    done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    p_n     = p_reg;
`endif
    case (state)
      IDLE: begin
        if (tx_start) begin
          state_n = START;
          s_n     = '0;
          b_n     = din;
          tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
          p_n     = ^din[DBIT-1:0];
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s == BIT_LAST) begin
            s_n     = '0;
            n_n     = '0;
            state_n = DATA;
            tx_n    = b[0];
          end else begin
            s_n = s + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == BIT_LAST) begin
            s_n = '0;
            b_n = b >> 1;
            if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_n = PARITY;
              tx_n    = p_reg;
`else
              state_n = STOP;
              tx_n    = 1'b1;
`endif
            end else begin
              n_n  = n + 3'd1;
              tx_n = b[1];
            end
          end else begin
            s_n = s + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s == BIT_LAST) begin
            s_n     = '0;
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            s_n = s + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s == STOP_LAST) begin
            state_n = IDLE;
            done    = 1'b1;
          end else begin
            s_n = s + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      default: state_n = IDLE;
`endif
    endcase
  end

  assign tx_done_tick = done;
  assign tx_ready     = (state == IDLE);
  assign tx           = tx_reg;

endmodule
